jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

- Round-robin arbiter and sequencer for a shared bank of WIDTH JK flip-flops.
- Up to NREQ requesters each post a 2-bit JK command (hold/set/clear/toggle) with a per-bit mask.
- The block grants one requester at a time, drives the J/K vectors for exactly one cycle, updates the bank, and acknowledges.
- It is the single owner of the JK bank; requesters never drive J/K directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK flip-flops in the bank
- iClk  input  1  clock, all state on rising edge
- iRst_n  input  1  reset, synchronous, active-low
- iReq  input  NREQ  request; bit i belongs to requester i
- iOp  input  2*NREQ  command, requester i uses [2i+1:2i]: 00 hold, 01 set (J=1,K=0), 10 clear (J=0,K=1), 11 toggle (J=1,K=1)
- iMask  input  WIDTH*NREQ  bit select, requester i uses [WIDTH*i +: WIDTH]; 1 = bit affected
- oGnt  output  NREQ  one-hot grant, held from APPLY through ACK
- oAck  output  NREQ  one-cycle completion pulse to the winner
- oJ  output  WIDTH  J vector applied to bank
- oK  output  WIDTH  K vector applied to bank
- oQ  output  WIDTH  bank state
- oQn  output  WIDTH  always ~oQ
- oBusy  output  1  high in APPLY and ACK

## Operation
- FSM has three states: IDLE, APPLY, ACK.
- IDLE:
  - If any iReq bit is set, select the winner by round-robin search starting at pointer ptr (ptr, ptr+1, ... mod NREQ).
  - Latch the winner index, its iOp slice and its iMask slice; set oGnt[winner]; go to APPLY.
  - If no iReq bit is set, stay in IDLE.
- APPLY:
  - oJ = mask & {WIDTH{op==01 | op==11}}.
  - oK = mask & {WIDTH{op==10 | op==11}}.
  - At the clock edge each bit updates as Q+ = (J & ~Q) | (~K & Q).
  - Unmasked bits and hold commands leave Q unchanged.
  - Go to ACK.
- ACK:
  - oAck[winner]=1, with oGnt still asserted.
  - At the clock edge: ptr = (winner+1) mod NREQ, oGnt cleared, go to IDLE.
- Outside APPLY, oJ and oK are 0.
- iOp and iMask are sampled only in the IDLE cycle that selects the winner; later changes are ignored.
- A requester must drop iReq in the cycle after its oAck. If iReq is still high in the next IDLE, it counts as a new request at lowest priority.
- Requests from non-winners are held off; they are never lost while iReq stays high.
- Hold (00) runs the full sequence and returns oAck.
- An all-zero mask behaves the same as hold.
- Reset values (iRst_n=0 at an edge, any state, mid-transaction included):
  - state IDLE, ptr 0.
  - oQ 0, oQn all ones.
  - oGnt, oAck, oJ, oK, oBusy all 0.
  - The aborted transaction is discarded: no oAck, Q not updated.

## Timing
- The IDLE edge that sees iReq is edge 0.
- oGnt and oBusy are high from edge 0 to edge 2.
- oJ/oK are valid between edge 0 and edge 1.
- oQ holds the new value after edge 1.
- oAck is high between edge 1 and edge 2.
- Throughput is one transaction per 3 cycles. IDLE lasts at least one cycle between transactions, so back-to-back transactions are 3 cycles apart.
- With all NREQ requesters continuously requesting, each is served once every 3*NREQ cycles (starvation-free).
- All outputs are registered except oJ and oK, which are decoded from state and the latched command.

## Test plan
- Reset: iRst_n=0 for 2 cycles with iReq=4'hF -> oQ=8'h00, oQn=8'hFF, oGnt=0, oAck=0, oBusy=0. First grant after release goes to requester 0.
- Set: requester 0, op 01, mask 8'h0F, from Q=0:
  - oGnt=4'b0001.
  - oJ=8'h0F and oK=0 for one cycle.
  - oQ=8'h0F after edge 1.
  - oAck=4'b0001 pulse at edge 1..2.
- Toggle then clear, starting from Q=8'h0F:
  - requester 1, op 11, mask 8'hFF -> oQ=8'hF0.
  - then requester 2, op 10, mask 8'h30 -> oQ=8'hC0.
- Fairness: iReq=4'hF held continuously, each requester dropping its request only for the cycle after its ack -> grant order 0,1,2,3,0,1, with grant rising edges 3 cycles apart.
- Hold and mask=0: op 00 mask 8'hFF, and op 11 mask 8'h00, starting from Q=8'hA5 -> oQ stays 8'hA5 and oAck is still issued for each.
- Reset mid-transaction: iRst_n=0 during APPLY of requester 2 (set, mask 8'hFF) -> no oAck, oQ=8'h00. After release with requesters 1 and 2 requesting, requester 1 is granted first (ptr back to 0).

Source files
------------

// File: rtl/jk_bank_arbiter_if.sv
// Request/grant bus between requesters and the JK bank arbiter.
// Pure wiring, no latency.
// Requesters hold iReq until oAck; the arbiter side owns every output.
interface jk_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       iReq;
   logic [2*NREQ-1:0]     iOp;
   logic [WIDTH*NREQ-1:0] iMask;
   logic [NREQ-1:0]       oGnt;
   logic [NREQ-1:0]       oAck;
   logic [WIDTH-1:0]      oJ;
   logic [WIDTH-1:0]      oK;
   logic [WIDTH-1:0]      oQ;
   logic [WIDTH-1:0]      oQn;
   logic                  oBusy;

   // requester side
   modport master (
      output iReq, iOp, iMask,
      input  oGnt, oAck, oJ, oK, oQ, oQn, oBusy
   );

   // arbiter side
   modport slave (
      input  iReq, iOp, iMask,
      output oGnt, oAck, oJ, oK, oQ, oQn, oBusy
   );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that owns a bank of WIDTH JK flops and applies one command per grant.
// Latency: grant at edge 0, bank updated at edge 1, ack pulse edge 1..2; one transaction per 3 cycles.
// Backpressure: losers keep iReq high and are served later; no request is dropped while iReq holds.
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input logic            iClk,
   input logic            iRst_n,
   jk_bank_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t           state;
   state_t           stateNext;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    winner;
   logic [IW-1:0]    pick;
   logic [IW:0]      pickSum;
   logic             found;
   logic [NREQ-1:0]  reqRot;
   logic [1:0]       opSel;
   logic [1:0]       opLat;
   logic [WIDTH-1:0] maskSel;
   logic [WIDTH-1:0] maskLat;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] jVec;
   logic [WIDTH-1:0] kVec;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  ack;
   logic             busy;

   // Round-robin search: rotate requests so bit 0 is the pointer, take the first set bit.
   always_comb begin
      reqRot  = NREQ'({bus.iReq, bus.iReq} >> ptr);
      found   = 1'b0;
      pick    = '0;
      pickSum = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && reqRot[k]) begin
            found   = 1'b1;
            pickSum = {1'b0, ptr} + (IW+1)'(k);
            if (pickSum >= (IW+1)'(NREQ)) begin
               pickSum = pickSum - (IW+1)'(NREQ);
            end
            pick = pickSum[IW-1:0];
         end
      end
   end

   // Mux out the candidate winner's command and mask.
   always_comb begin
      opSel   = '0;
      maskSel = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (pick == IW'(r)) begin
            opSel   = bus.iOp[2*r +: 2];
            maskSel = bus.iMask[WIDTH*r +: WIDTH];
         end
      end
   end

   // State register.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state: IDLE waits for a request, then APPLY and ACK each take one cycle.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    stateNext = found ? APPLY : IDLE;
         APPLY:   stateNext = ACK;
         ACK:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // J/K drive exists only during APPLY; op bit 0 means J, op bit 1 means K.
   always_comb begin
      jVec = '0;
      kVec = '0;
      if (state == APPLY) begin
         jVec = maskLat & {WIDTH{opLat[0]}};
         kVec = maskLat & {WIDTH{opLat[1]}};
      end
   end

   // Latch the winner, update the bank, pulse ack and advance the pointer on completion.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         ptr     <= '0;
         winner  <= '0;
         opLat   <= '0;
         maskLat <= '0;
         q       <= '0;
         gnt     <= '0;
         ack     <= '0;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  winner  <= pick;
                  opLat   <= opSel;
                  maskLat <= maskSel;
                  gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  busy    <= 1'b1;
               end
            end
            APPLY: begin
               q   <= (jVec & ~q) | (~kVec & q);
               ack <= gnt;
            end
            ACK: begin
               ptr  <= (winner == IW'(NREQ-1)) ? '0 : winner + IW'(1);
               gnt  <= '0;
               ack  <= '0;
               busy <= 1'b0;
            end
            default: begin
               gnt  <= '0;
               ack  <= '0;
               busy <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oGnt  = gnt;
   assign bus.oAck  = ack;
   assign bus.oJ    = jVec;
   assign bus.oK    = kVec;
   assign bus.oQ    = q;
   assign bus.oQn   = ~q;
   assign bus.oBusy = busy;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for the JK bank arbiter.
// Each step advances one clock and checks outputs 1 time unit after the edge.
// Requesters are modelled by driving the interface directly from one initial block.
module tb_jk_bank_arbiter;
   logic clk  = 1'b0;
   logic rstN = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   lastGnt = 0;

   jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

   jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .iClk   (clk),
      .iRst_n (rstN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setCmd(input int r, input logic [1:0] op, input logic [7:0] m);
      bus.iOp[2*r +: 2]   = op;
      bus.iMask[8*r +: 8] = m;
   endtask

   initial begin
      logic [3:0] wBit;

      // reset with every requester asking
      rstN      = 1'b0;
      bus.iReq  = 4'hF;
      bus.iOp   = '0;
      bus.iMask = '0;
      tick; tick;
      check("rst_q",    bus.oQ,    8'h00);
      check("rst_qn",   bus.oQn,   8'hFF);
      check("rst_gnt",  bus.oGnt,  4'h0);
      check("rst_ack",  bus.oAck,  4'h0);
      check("rst_busy", bus.oBusy, 1'b0);
      check("rst_j",    bus.oJ,    8'h00);
      check("rst_k",    bus.oK,    8'h00);

      // set: requester 0 wins first after release
      setCmd(0, 2'b01, 8'h0F);
      setCmd(1, 2'b11, 8'hFF);
      setCmd(2, 2'b10, 8'hFF);
      setCmd(3, 2'b11, 8'hFF);
      rstN = 1'b1;
      tick;
      check("set_gnt",  bus.oGnt,  4'b0001);
      check("set_busy", bus.oBusy, 1'b1);
      check("set_j",    bus.oJ,    8'h0F);
      check("set_k",    bus.oK,    8'h00);
      check("set_q0",   bus.oQ,    8'h00);
      bus.iReq = 4'h0;
      tick;
      check("set_q",    bus.oQ,    8'h0F);
      check("set_qn",   bus.oQn,   8'hF0);
      check("set_ack",  bus.oAck,  4'b0001);
      check("set_gnt1", bus.oGnt,  4'b0001);
      check("set_j1",   bus.oJ,    8'h00);
      check("set_k1",   bus.oK,    8'h00);
      tick;
      check("set_gnt2", bus.oGnt,  4'h0);
      check("set_ack2", bus.oAck,  4'h0);
      check("set_busy2", bus.oBusy, 1'b0);

      // toggle: inputs scrambled after selection must be ignored
      setCmd(1, 2'b11, 8'hFF);
      bus.iReq = 4'b0010;
      tick;
      check("tog_gnt", bus.oGnt, 4'b0010);
      bus.iReq  = 4'h0;
      bus.iOp   = '0;
      bus.iMask = '0;
      check("tog_j", bus.oJ, 8'hFF);
      check("tog_k", bus.oK, 8'hFF);
      tick;
      check("tog_q",   bus.oQ,   8'hF0);
      check("tog_ack", bus.oAck, 4'b0010);
      tick;

      // clear
      setCmd(2, 2'b10, 8'h30);
      bus.iReq = 4'b0100;
      tick;
      check("clr_gnt", bus.oGnt, 4'b0100);
      check("clr_j",   bus.oJ,   8'h00);
      check("clr_k",   bus.oK,   8'h30);
      bus.iReq = 4'h0;
      tick;
      check("clr_q",   bus.oQ,   8'hC0);
      check("clr_ack", bus.oAck, 4'b0100);
      tick;

      // fairness from a fresh reset, all hold commands
      rstN     = 1'b0;
      bus.iReq = 4'hF;
      bus.iOp  = '0;
      tick;
      check("fair_rstq", bus.oQ, 8'h00);
      rstN = 1'b1;
      for (int n = 0; n < 6; n++) begin
         wBit = 4'b0001 << (n % 4);
         tick;
         bus.iReq = 4'hF;
         check("fair_gnt", bus.oGnt, wBit);
         if (n > 0) check("fair_gap", cyc - lastGnt, 3);
         lastGnt = cyc;
         tick;
         check("fair_ack", bus.oAck, wBit);
         tick;
         check("fair_idle", bus.oGnt, 4'h0);
         bus.iReq = 4'hF & ~wBit;
      end
      bus.iReq = 4'h0;
      tick;

      // load A5 via requester 2 (pointer now at 2)
      setCmd(2, 2'b01, 8'hA5);
      bus.iReq = 4'b0100;
      tick;
      check("a5_gnt", bus.oGnt, 4'b0100);
      bus.iReq = 4'h0;
      tick;
      check("a5_q", bus.oQ, 8'hA5);
      tick;

      // hold with full mask
      setCmd(3, 2'b00, 8'hFF);
      bus.iReq = 4'b1000;
      tick;
      check("hold_gnt", bus.oGnt, 4'b1000);
      check("hold_j",   bus.oJ,   8'h00);
      check("hold_k",   bus.oK,   8'h00);
      bus.iReq = 4'h0;
      tick;
      check("hold_q",   bus.oQ,   8'hA5);
      check("hold_ack", bus.oAck, 4'b1000);
      tick;

      // toggle with empty mask
      setCmd(0, 2'b11, 8'h00);
      bus.iReq = 4'b0001;
      tick;
      check("m0_gnt", bus.oGnt, 4'b0001);
      check("m0_j",   bus.oJ,   8'h00);
      check("m0_k",   bus.oK,   8'h00);
      bus.iReq = 4'h0;
      tick;
      check("m0_q",   bus.oQ,   8'hA5);
      check("m0_ack", bus.oAck, 4'b0001);
      tick;

      // reset during APPLY aborts the transaction
      setCmd(2, 2'b01, 8'hFF);
      setCmd(1, 2'b00, 8'hFF);
      bus.iReq = 4'b0100;
      tick;
      check("mid_gnt", bus.oGnt, 4'b0100);
      check("mid_j",   bus.oJ,   8'hFF);
      rstN = 1'b0;
      tick;
      check("mid_ack",  bus.oAck,  4'h0);
      check("mid_q",    bus.oQ,    8'h00);
      check("mid_qn",   bus.oQn,   8'hFF);
      check("mid_gnt0", bus.oGnt,  4'h0);
      check("mid_busy", bus.oBusy, 1'b0);
      rstN     = 1'b1;
      bus.iReq = 4'b0110;
      tick;
      check("post_gnt", bus.oGnt, 4'b0010);
      bus.iReq = 4'h0;
      tick;
      check("post_ack", bus.oAck, 4'b0010);
      check("post_q",   bus.oQ,   8'h00);
      tick;
      check("post_idle", bus.oBusy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
